prog_streamer: RTL and testbench

PROG_STREAMER -- requirements
Module: prog_streamer

---
 rtl/prog_streamer_pkg.sv | 24 ++
 rtl/prog_buffer.sv | 32 +++
 rtl/prog_streamer.sv | 114 +++++++++++
 tb/tb_prog_streamer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_streamer_pkg.sv
// Shared constants for the programming streamer: FSM state encodings,
// core NOOP words, default geometry and the byte-pair word packer.
package prog_streamer_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int WORD_W_DEF = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CPURST = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Bit 0 of the core bus selects execution (1) vs programming (0) mode.
  localparam logic [15:0] NOOP_EXEC = 16'h0001;
  localparam logic [15:0] NOOP_PROG = 16'h0000;

  // Only the upper seven bits of the low byte survive; bit 0 is forced to
  // programming mode.
  function automatic logic [15:0] pack_word(input logic [7:0] hi,
                                            input logic [6:0] lo7);
    return {hi, lo7, 1'b0};
  endfunction

endpackage

// File: rtl/prog_buffer.sv
// DEPTH x WORD_W register file holding program words: one write port,
// one asynchronous read port, synchronous reset and clear.
module prog_buffer #(
  parameter int DEPTH  = 8,
  parameter int WORD_W = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: this array is reset on purpose -- unwritten slots must read back as
  // programming-mode zero words, so it builds as flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      mem <= '{default: '0};
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/prog_streamer.sv
// Collects host bytes into program words, then holds the core in reset for
// one cycle and streams every buffer slot onto the core's input bus.
module prog_streamer
  import prog_streamer_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WORD_W-1:0]        prog_bus,
  output logic                     cpu_rst_n
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [1:0]        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              phase;
  logic [6:0]        low_hi7;
  logic              start_acc, wr_acc, wr_en, clr;
  logic [WORD_W-1:0] wr_word, rd_data, bus_nxt;

  assign start_acc = start && (state == ST_IDLE);
  // start takes priority over a byte offered in the same cycle.
  assign wr_ready  = (state == ST_IDLE) && (count < CNT_W'(DEPTH)) && !start;
  assign wr_acc    = wr_valid && wr_ready;
  assign wr_en     = wr_acc && phase;
  assign wr_word   = WORD_W'(pack_word(wr_data, low_hi7));
  assign clr       = (state_nxt == ST_DONE);

  prog_buffer #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_addr (count[IDX_W-1:0]),
    .wr_data (wr_word),
    .rd_addr (idx_nxt),
    .rd_data (rd_data)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE:   if (start_acc) state_nxt = ST_CPURST;
      ST_CPURST: begin
        state_nxt = ST_STREAM;
        idx_nxt   = '0;
      end
      ST_STREAM: begin
        if (idx == IDX_W'(DEPTH - 1)) state_nxt = ST_DONE;
        else                          idx_nxt   = idx + IDX_W'(1);
      end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The bus is registered from next-state values so it lines up with the
  // state it belongs to; slots at or above count always emit a zero word.
  always_comb begin
    bus_nxt = WORD_W'(NOOP_EXEC);
    if (state_nxt == ST_STREAM) begin
      bus_nxt = ({1'b0, idx_nxt} < count) ? rd_data : WORD_W'(NOOP_PROG);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      count     <= '0;
      phase     <= 1'b0;
      low_hi7   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_rst_n <= 1'b0;
      prog_bus  <= WORD_W'(NOOP_EXEC);
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      busy      <= (state_nxt == ST_CPURST) || (state_nxt == ST_STREAM);
      done      <= (state_nxt == ST_DONE);
      cpu_rst_n <= (state_nxt != ST_CPURST);
      prog_bus  <= bus_nxt;

      if (clr)        count <= '0;
      else if (wr_en) count <= count + CNT_W'(1);

      // An accepted start drops any half-received word.
      if (start_acc) begin
        phase <= 1'b0;
      end else if (wr_acc) begin
        phase <= ~phase;
        if (!phase) low_hi7 <= wr_data[7:1];
      end
    end
  end

endmodule

// File: tb/tb_prog_streamer.sv
// Directed bench for prog_streamer at DEPTH=8, WORD_W=16.
module tb_prog_streamer;

  typedef struct packed {
    logic             cr_rst_n;
    logic             cr_busy;
    logic [15:0]      cr_bus;
    logic [7:0][15:0] words;
    logic             stream_ok;
    logic             end_done;
    logic [15:0]      end_bus;
    logic [3:0]       end_count;
    logic             end_busy;
    logic             idle_done;
  } stream_obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        wr_valid = 1'b0;
  logic        start = 1'b0;
  logic        wr_ready, busy, done, cpu_rst_n;
  logic [3:0]  count;
  logic [15:0] prog_bus;

  int n_checks = 0;
  int n_fail   = 0;
  int done_pulses = 0;

  prog_streamer #(.DEPTH(8), .WORD_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .prog_bus  (prog_bus),
    .cpu_rst_n (cpu_rst_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  // Start a stream and capture the bus and flags cycle by cycle. With
  // disturb set, start and a byte are offered during stream cycles 1..3.
  task automatic run_stream(input bit disturb, output stream_obs_t o);
    o = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    o.cr_rst_n  = cpu_rst_n;
    o.cr_busy   = busy;
    o.cr_bus    = prog_bus;
    o.stream_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (disturb && k >= 2 && k <= 4) begin
        start = 1'b1; wr_valid = 1'b1; wr_data = 8'hFF;
      end
      tick();
      start = 1'b0; wr_valid = 1'b0;
      o.words[k] = prog_bus;
      if (busy !== 1'b1 || cpu_rst_n !== 1'b1 || done !== 1'b0 || wr_ready !== 1'b0)
        o.stream_ok = 1'b0;
    end
    tick();
    o.end_done  = done;
    o.end_bus   = prog_bus;
    o.end_count = count;
    o.end_busy  = busy;
    tick();
    o.idle_done = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n); end
    n_checks++; if (prog_bus !== 16'h0001) begin n_fail++; $display("FAIL reset_prog_bus: got %h want 0001", prog_bus); end
    rst_n = 1'b1;
    tick();
    n_checks++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL post_reset_cpu_rst_n: got %b want 1", cpu_rst_n); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_single_word();
    stream_obs_t o;
    int d0;
    send_byte(8'h12);
    send_byte(8'h34);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    d0 = done_pulses;
    run_stream(1'b0, o);
    n_checks++; if (o.cr_rst_n !== 1'b0) begin n_fail++; $display("FAIL single_cpurst_low: got %b want 0", o.cr_rst_n); end
    n_checks++; if (o.cr_busy !== 1'b1) begin n_fail++; $display("FAIL single_cpurst_busy: got %b want 1", o.cr_busy); end
    n_checks++; if (o.cr_bus !== 16'h0001) begin n_fail++; $display("FAIL single_cpurst_bus: got %h want 0001", o.cr_bus); end
    n_checks++; if (o.words[0] !== 16'h3412) begin n_fail++; $display("FAIL single_word0: got %h want 3412", o.words[0]); end
    n_checks++; if (o.words[7:1] !== '0) begin n_fail++; $display("FAIL single_tail_zero: got %h want 0", o.words[7:1]); end
    n_checks++; if (o.stream_ok !== 1'b1) begin n_fail++; $display("FAIL single_stream_flags: got %b want 1", o.stream_ok); end
    n_checks++; if (o.end_done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", o.end_done); end
    n_checks++; if (o.end_bus !== 16'h0001) begin n_fail++; $display("FAIL single_done_bus: got %h want 0001", o.end_bus); end
    n_checks++; if (o.end_busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy: got %b want 0", o.end_busy); end
    n_checks++; if (o.idle_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", o.idle_done); end
    n_checks++; if (done_pulses - d0 !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_pulses - d0); end
  endtask

  task automatic test_full();
    stream_obs_t o;
    logic [15:0] exp_words [8] = '{16'hA00E, 16'hA11E, 16'hA22E, 16'hA33E,
                                   16'hA44E, 16'hA55E, 16'hA66E, 16'hA77E};
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h0F + 8'(16 * i));
      if (i == 7) begin
        n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_count_15: got %0d want 7", count); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_15: got %b want 1", wr_ready); end
      end
      send_byte(8'hA0 + 8'(i));
    end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count_16: got %0d want 8", count); end
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_16: got %b want 0", wr_ready); end
    send_byte(8'h55);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_byte17_ignored: got %0d want 8", count); end
    run_stream(1'b0, o);
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (o.words[k] !== exp_words[k]) begin n_fail++; $display("FAIL full_word%0d: got %h want %h", k, o.words[k], exp_words[k]); end
    end
    n_checks++; if (o.end_count !== 4'd0) begin n_fail++; $display("FAIL full_count_after: got %0d want 0", o.end_count); end
  endtask

  task automatic test_odd_discard();
    stream_obs_t o;
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'hEF);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL odd_count: got %0d want 1", count); end
    run_stream(1'b0, o);
    n_checks++; if (o.words[0] !== 16'hCDAA) begin n_fail++; $display("FAIL odd_word0: got %h want cdaa", o.words[0]); end
    n_checks++; if (o.words[7:1] !== '0) begin n_fail++; $display("FAIL odd_tail_zero: got %h want 0", o.words[7:1]); end
    n_checks++; if (o.end_count !== 4'd0) begin n_fail++; $display("FAIL odd_count_after: got %0d want 0", o.end_count); end
  endtask

  task automatic test_back_to_back();
    stream_obs_t o;
    send_byte(8'h02);
    send_byte(8'h00);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL b2b_count: got %0d want 1", count); end
    run_stream(1'b0, o);
    n_checks++; if (o.words[0] !== 16'h0002) begin n_fail++; $display("FAIL b2b_word0: got %h want 0002", o.words[0]); end
    n_checks++; if (o.words[7:1] !== '0) begin n_fail++; $display("FAIL b2b_tail_zero: got %h want 0", o.words[7:1]); end
  endtask

  task automatic test_ignore_in_stream();
    stream_obs_t o;
    int d0;
    send_byte(8'h56);
    send_byte(8'h78);
    d0 = done_pulses;
    run_stream(1'b1, o);
    repeat (3) tick();
    n_checks++; if (o.words[0] !== 16'h7856) begin n_fail++; $display("FAIL ignore_word0: got %h want 7856", o.words[0]); end
    n_checks++; if (o.words[7:1] !== '0) begin n_fail++; $display("FAIL ignore_tail_zero: got %h want 0", o.words[7:1]); end
    n_checks++; if (o.stream_ok !== 1'b1) begin n_fail++; $display("FAIL ignore_stream_flags: got %b want 1", o.stream_ok); end
    n_checks++; if (done_pulses - d0 !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d want 1", done_pulses - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: got %b want 0", busy); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL ignore_count: got %0d want 0", count); end
  endtask

  task automatic test_start_wins();
    wr_data  = 8'h57;
    wr_valid = 1'b1;
    start    = 1'b1;
    #1;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL startwins_ready: got %b want 0", wr_ready); end
    tick();
    start = 1'b0; wr_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL startwins_busy: got %b want 1", busy); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL startwins_count: got %0d want 0", count); end
    for (int c = 0; c < 20 && done !== 1'b1; c++) tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL startwins_done_timeout: got %b want 1", done); end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    stream_obs_t o;
    int d0;
    send_byte(8'h9A);
    send_byte(8'hBC);
    d0 = done_pulses;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL abort_count: got %0d want 0", count); end
    n_checks++; if (prog_bus !== 16'h0001) begin n_fail++; $display("FAIL abort_bus: got %h want 0001", prog_bus); end
    n_checks++; if (cpu_rst_n !== 1'b0) begin n_fail++; $display("FAIL abort_cpu_rst_n: got %b want 0", cpu_rst_n); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done); end
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (done_pulses - d0 !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_pulses - d0); end
    n_checks++; if (cpu_rst_n !== 1'b1) begin n_fail++; $display("FAIL abort_release: got %b want 1", cpu_rst_n); end
    // Empty buffer after reset: a start must still stream eight zero words.
    run_stream(1'b0, o);
    n_checks++; if (o.words !== '0) begin n_fail++; $display("FAIL empty_words: got %h want 0", o.words); end
    n_checks++; if (o.end_done !== 1'b1) begin n_fail++; $display("FAIL empty_done: got %b want 1", o.end_done); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full();
    test_odd_discard();
    test_back_to_back();
    test_ignore_in_stream();
    test_start_wins();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
